// File: rtl/decoder_rr_scheduler.sv
// Round-robin scheduler sharing one decoder-driven select bus among 8 requesters.
// Grant registered one edge after a request is seen in IDLE; one idle cycle between grants.
// A grant is held until done, request drop, en=0, or MAX_HOLD cycles with others waiting.
module decoder_rr_scheduler #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [2:0]    ptr;
  logic [CW-1:0] hold_cnt;

  logic [2:0]    pick_idx;
  logic          pick_found;
  logic [2:0]    cand;
  logic [7:0]    others;
  logic          release_now;

  // Scan requests starting at ptr; the first set bit wins.
  always_comb begin
    pick_idx   = ptr;
    pick_found = 1'b0;
    cand       = ptr;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!pick_found && req[cand]) begin
        pick_idx   = cand;
        pick_found = 1'b1;
      end
    end
  end

  // Release conditions for the current holder; timeout only counts when someone else waits.
  always_comb begin
    others      = req & ~(8'h01 << gnt_idx);
    release_now = done || !req[gnt_idx] || !en ||
                  ((hold_cnt == HOLD_LAST) && (others != 8'h00));
  end

  // One-hot select decoded from the registered index; empty when no grant is active.
  assign gnt = gnt_valid ? (8'h01 << gnt_idx) : 8'h00;

  // Two-state grant FSM with registered index/valid and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= 3'd0;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            state     <= GRANT;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            // Just-served requester becomes lowest priority.
            ptr       <= gnt_idx + 3'd1;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt  <= hold_cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
